// File: rtl/svm_pkg.sv
// Shared widths, saturation limits and FSM encoding for the SVM alpha accumulator.
package svm_pkg;

    localparam int ALPHA_WIDTH  = 12;
    localparam int KERNEL_WIDTH = 16;
    localparam int ACC_WIDTH    = 40;
    localparam int PROD_WIDTH   = ALPHA_WIDTH + KERNEL_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } svm_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/svm_signal_delay.sv
// N-stage, W-bit shift register with synchronous reset; N=0 is a plain wire.
module svm_signal_delay #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] stages [N];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < N; i++) stages[i] <= '0;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[N-1];
        end
    endgenerate

endmodule

// File: rtl/svm_alpha_accumulator.sv
// Multiply-accumulates alpha*kernel over all support vectors, emitting group partial sums and a biased decision.
// Optional build macro ACC_SATURATE_EN: saturating accumulation plus a sticky accOverflow output.
module svm_alpha_accumulator
    import svm_pkg::*;
#(
    parameter int alphaWidth    = ALPHA_WIDTH,
    parameter int kernelWidth   = KERNEL_WIDTH,
    parameter int accWidth      = ACC_WIDTH,
    parameter int alphaMemDepth = 100,
    parameter int alignDelay    = 2,
    parameter logic signed [accWidth-1:0] bias = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          processedScalars,
    input  logic                          lastScalar,
    input  logic signed [alphaWidth-1:0]  alpha,
    input  logic signed [kernelWidth-1:0] kernelValue,
    output logic signed [accWidth-1:0]    partialSum,
    output logic                          partialValid,
    output logic signed [accWidth-1:0]    score,
    output logic                          decision,
    output logic                          decisionValid,
    output logic                          busy
`ifdef ACC_SATURATE_EN
    ,
    output logic                          accOverflow
`endif
);

    localparam int prod_w        = alphaWidth + kernelWidth;
    localparam int sum_w         = max_int(accWidth, prod_w) + 1;
    localparam int min_acc_width = prod_w + $clog2(alphaMemDepth);
`ifdef ACC_SATURATE_EN
    localparam bit sat_en = 1'b1;
`else
    localparam bit sat_en = 1'b0;
`endif

    // A wrapping accumulator must hold the worst-case sum; saturation tolerates a narrower one.
    generate
        if (!sat_en && accWidth < min_acc_width) begin : g_width_check
            $error("accWidth too narrow for alphaMemDepth products");
        end
    endgenerate

    logic en_d, ps_d, ls_d, ls_prev;
    logic en_q, ps_q, lr_q;
    logic signed [prod_w-1:0]   prod_c, prod_q;
    logic signed [sum_w-1:0]    wide_sum;
    logic signed [accWidth-1:0] acc, sum_c, score_c;
    svm_state_e state_q, state_n;

    svm_signal_delay #(.N(alignDelay), .W(3)) u_align (
        .clock (clock),
        .reset (reset),
        .d     ({enable, processedScalars, lastScalar}),
        .q     ({en_d, ps_d, ls_d})
    );

    assign prod_c = prod_w'(alpha) * prod_w'(kernelValue);

    // ls_prev only follows qualified cycles so a rise during an enable gap is still seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            ls_prev <= 1'b0;
            en_q    <= 1'b0;
            ps_q    <= 1'b0;
            lr_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            if (en_d) ls_prev <= ls_d;
            en_q   <= en_d;
            ps_q   <= en_d & ps_d;
            lr_q   <= en_d & ls_d & ~ls_prev;
            prod_q <= prod_c;
        end
    end

    assign wide_sum = sum_w'(acc) + sum_w'(prod_q);

`ifdef ACC_SATURATE_EN
    localparam logic signed [accWidth-1:0] acc_max = {1'b0, {(accWidth-1){1'b1}}};
    localparam logic signed [accWidth-1:0] acc_min = {1'b1, {(accWidth-1){1'b0}}};
    logic ovf_c;

    always_comb begin
        sum_c = accWidth'(wide_sum);
        ovf_c = 1'b0;
        if (wide_sum > sum_w'(acc_max)) begin
            sum_c = acc_max;
            ovf_c = 1'b1;
        end else if (wide_sum < sum_w'(acc_min)) begin
            sum_c = acc_min;
            ovf_c = 1'b1;
        end
    end
`else
    assign sum_c = accWidth'(wide_sum);
`endif

    assign score_c = sum_c + bias;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (en_d) state_n = ACCUM;
            ACCUM:   if (en_q && lr_q) state_n = FINAL;
            FINAL:   state_n = DONE;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == ACCUM) || (state_q == FINAL) || (state_q == IDLE && en_d);
        decisionValid = (state_q == FINAL);
    end

    // partialSum excludes bias; score/decision are captured as FINAL is entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            partialSum   <= '0;
            partialValid <= 1'b0;
            score        <= '0;
            decision     <= 1'b0;
`ifdef ACC_SATURATE_EN
            accOverflow  <= 1'b0;
`endif
        end else begin
            partialValid <= 1'b0;
            if (state_q == ACCUM && en_q) begin
                acc <= sum_c;
`ifdef ACC_SATURATE_EN
                if (ovf_c) accOverflow <= 1'b1;
`endif
                if (ps_q) begin
                    partialSum   <= sum_c;
                    partialValid <= 1'b1;
                end
                if (lr_q) begin
                    score    <= score_c;
                    decision <= ~score_c[accWidth-1];
                end
            end
        end
    end

endmodule
